// File: rtl/ps2_key_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ps2_key_rx                                                       |
// | Brief   : PS/2 keyboard receiver; filters the raw lines, deserializes      |
// |           11-bit frames and assembles scan-code bytes into 65-bit key      |
// |           events with a toggle strobe. Optional odd-parity checking is     |
// |           enabled by defining PS2_PARITY_CHK_EN.                           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ps2_key_rx #(
  parameter int CLK_KHZ    = 32000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [64:0] ps2_key,
  output logic        frame_err
);

  localparam int                  c_timeout_cyc = (CLK_KHZ * TIMEOUT_US) / 1000;
  localparam int                  c_tmr_w       = $clog2(c_timeout_cyc + 1);
  localparam logic [c_tmr_w-1:0]  c_timeout     = c_tmr_w'(c_timeout_cyc);
  localparam logic [7:0]          c_flt_last    = 8'(FILTER_LEN - 1);
  localparam logic [7:0]          c_code_e0     = 8'hE0;
  localparam logic [7:0]          c_code_f0     = 8'hF0;
  localparam logic [7:0]          c_code_e1     = 8'hE1;
  localparam logic [7:0]          c_code_12     = 8'h12;
  localparam logic [3:0]          c_cnt_max     = 4'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

  // ---------------------------------------------------------------- input conditioning
  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic       r_clk_filt;
  logic [7:0] r_flt_cnt;
  logic       r_fall;
  logic       r_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
    end
  end

  // The filtered clock flips only after FILTER_LEN consecutive differing samples;
  // the data bit is captured in the same cycle the falling edge is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_filt <= 1'b1;
      r_flt_cnt  <= 8'd0;
      r_fall     <= 1'b0;
      r_bit      <= 1'b1;
    end else begin
      r_fall <= 1'b0;
      if (r_clk_sync[1] == r_clk_filt) begin
        r_flt_cnt <= 8'd0;
      end else if (r_flt_cnt == c_flt_last) begin
        r_clk_filt <= r_clk_sync[1];
        r_flt_cnt  <= 8'd0;
        r_fall     <= ~r_clk_sync[1];
        r_bit      <= r_data_sync[1];
      end else begin
        r_flt_cnt <= r_flt_cnt + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------- frame FSM
  frame_state_e       r_state;
  frame_state_e       w_state_nxt;
  logic [7:0]         r_shift;
  logic [2:0]         r_bit_cnt;
  logic [c_tmr_w-1:0] r_frame_tmr;
  logic               r_byte_valid;
  logic [7:0]         r_byte;
  logic               r_frame_err;
  logic               w_frame_to;
  logic               w_shift_en;
  logic               w_par_en;
  logic               w_byte_ok;
  logic               w_err;
  logic               w_par_ok;

  assign w_frame_to = (r_state != IDLE) && (r_frame_tmr == c_timeout) && !r_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_byte_ok   = 1'b0;
    w_err       = 1'b0;
    if (w_frame_to) begin
      w_state_nxt = IDLE;
      w_err       = 1'b1;
    end else if (r_fall) begin
      unique case (r_state)
        IDLE: begin
          if (!r_bit) w_state_nxt = DATA;
        end
        DATA: begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
        end
        PARITY: begin
          w_par_en    = 1'b1;
          w_state_nxt = STOP;
        end
        STOP: begin
          w_state_nxt = IDLE;
          if (r_bit && w_par_ok) w_byte_ok = 1'b1;
          else                   w_err     = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

`ifdef PS2_PARITY_CHK_EN
  logic r_par_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_par_ok <= 1'b1;
    end else if (w_par_en) begin
      r_par_ok <= (^r_shift) ^ r_bit;
    end
  end

  assign w_par_ok = r_par_ok;
`else
  logic w_par_unused;

  assign w_par_unused = w_par_en;
  assign w_par_ok     = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift      <= 8'd0;
      r_bit_cnt    <= 3'd0;
      r_frame_tmr  <= '0;
      r_byte_valid <= 1'b0;
      r_byte       <= 8'd0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= w_byte_ok;
      r_frame_err  <= w_err;
      if (w_byte_ok) r_byte <= r_shift;
      if (w_shift_en) begin
        r_shift   <= {r_bit, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end else if (r_state == IDLE) begin
        r_bit_cnt <= 3'd0;
      end
      if (r_fall || r_state == IDLE)  r_frame_tmr <= '0;
      else if (r_frame_tmr != c_timeout) r_frame_tmr <= r_frame_tmr + 1'b1;
    end
  end

  // ---------------------------------------------------------------- sequence assembly
  logic [63:0]        r_buf;
  logic [3:0]         r_cnt;
  logic               r_in_pause;
  logic [64:0]        r_key;
  logic [c_tmr_w-1:0] r_seq_tmr;
  logic [63:0]        w_buf_nxt;
  logic [3:0]         w_cnt_inc;
  logic [63:0]        w_first_sh;
  logic [7:0]         w_first;
  logic               w_emit;
  logic               w_hold;
  logic               w_drop;
  logic               w_pause_set;
  logic               w_seq_to;

  assign w_buf_nxt  = {r_buf[55:0], r_byte};
  assign w_cnt_inc  = (r_cnt == c_cnt_max) ? c_cnt_max : r_cnt + 4'd1;
  // Oldest buffered byte, used to recognise the E0-led fake-shift sequences.
  assign w_first_sh = r_buf >> {r_cnt - 4'd1, 3'b000};
  assign w_first    = w_first_sh[7:0];
  assign w_seq_to   = (r_cnt != 4'd0) && (r_seq_tmr == c_timeout);

  always_comb begin
    w_emit      = 1'b0;
    w_hold      = 1'b0;
    w_drop      = 1'b0;
    w_pause_set = 1'b0;
    if (r_byte_valid) begin
      if (r_in_pause) begin
        if (w_cnt_inc == c_cnt_max) w_emit = 1'b1;
        else                        w_hold = 1'b1;
      end else if (r_cnt == c_cnt_max) begin
        w_drop = 1'b1;
      end else if (r_byte == c_code_e1 && r_cnt == 4'd0) begin
        w_hold      = 1'b1;
        w_pause_set = 1'b1;
      end else if (r_byte == c_code_e0 || r_byte == c_code_f0) begin
        w_hold = 1'b1;
      end else if (r_byte == c_code_12 && r_cnt != 4'd0 && w_first == c_code_e0) begin
        w_drop = 1'b1;
      end else begin
        w_emit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf      <= 64'd0;
      r_cnt      <= 4'd0;
      r_in_pause <= 1'b0;
      r_key      <= 65'd0;
      r_seq_tmr  <= '0;
    end else begin
      if (w_emit) begin
        r_key      <= {~r_key[64], w_buf_nxt};
        r_buf      <= 64'd0;
        r_cnt      <= 4'd0;
        r_in_pause <= 1'b0;
      end else if (w_drop || (!r_byte_valid && w_seq_to)) begin
        r_buf      <= 64'd0;
        r_cnt      <= 4'd0;
        r_in_pause <= 1'b0;
      end else if (w_hold) begin
        r_buf      <= w_buf_nxt;
        r_cnt      <= w_cnt_inc;
        r_in_pause <= r_in_pause | w_pause_set;
      end
      if (r_byte_valid || r_cnt == 4'd0) r_seq_tmr <= '0;
      else if (r_seq_tmr != c_timeout)   r_seq_tmr <= r_seq_tmr + 1'b1;
    end
  end

  assign ps2_key   = r_key;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ps2_key_rx                                                    |
// | Brief   : Self-checking bench for ps2_key_rx: vector table, corner-case    |
// |           sequences and random scan-code streams against a queue model.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ps2_key_rx;

  localparam int CLK_KHZ    = 1000;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT_US = 2000;
  localparam int HALF       = 16;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [64:0] ps2_key;
  logic        frame_err;

  ps2_key_rx #(
    .CLK_KHZ    (CLK_KHZ),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int          tests      = 0;
  int          fails      = 0;
  int          err_pulses = 0;
  int          err_long   = 0;
  logic        prev_tog   = 1'b0;
  logic        prev_err   = 1'b0;
  logic        exp_tog    = 1'b0;
  logic [63:0] key_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  pend[$];

  // Every strobe toggle while out of reset is one emitted event.
  always @(negedge clk) begin
    if (reset_n && ps2_key[64] != prev_tog) key_q.push_back(ps2_key[63:0]);
    prev_tog = ps2_key[64];
    if (frame_err) begin
      err_pulses++;
      if (prev_err) err_long++;
    end
    prev_err = frame_err;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device-side frame: data changes while the clock is high; glitch_bit >= 0
  // injects a short low pulse into that bit's high phase.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip,
                            input int nbits, input int glitch_bit);
    logic [10:0] f;
    f = {stop, ~(^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (i == glitch_bit) begin
        wait_cyc(9);
        ps2_clk = 1'b0;
        wait_cyc(4);
        ps2_clk = 1'b1;
        wait_cyc(3);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    send_frame(b, 1'b1, 1'b0, 11, -1);
    wait_cyc(gap);
  endtask

  task automatic model_emit();
    logic [63:0] w;
    w = 64'd0;
    foreach (pend[i]) w = {w[55:0], pend[i]};
    exp_q.push_back(w);
    pend.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    pend.push_back(b);
    if (pend[0] == 8'hE1) begin
      if (pend.size() == 8) model_emit();
    end else if (pend.size() > 8) begin
      pend.delete();
    end else if (b == 8'hE0 || b == 8'hF0) begin
      // prefix: keep collecting
    end else if (b == 8'h12 && pend[0] == 8'hE0) begin
      pend.delete();
    end else begin
      model_emit();
    end
  endtask

  task automatic expect_events(input string name, input int emits, input logic [63:0] key,
                               input int errs);
    if (emits % 2 == 1) exp_tog = ~exp_tog;
    check({name, "_emits"}, 64'(key_q.size()), 64'(emits));
    check({name, "_key"}, (key_q.size() > 0) ? key_q[key_q.size()-1] : 64'h0, key);
    check({name, "_tog"}, 64'(ps2_key[64]), 64'(exp_tog));
    check({name, "_err"}, 64'(err_pulses), 64'(errs));
    check({name, "_errw"}, 64'(err_long), 64'd0);
    key_q.delete();
    err_pulses = 0;
    err_long   = 0;
  endtask

  typedef struct {
    int          n;
    logic [63:0] bytes;
    int          emits;
    logic [63:0] key;
  } vec_t;

  vec_t        vecs[6];
  logic [7:0]  codes[14];
  logic [7:0]  seq[$];
  logic [63:0] bts;

  initial begin
    vecs[0] = '{1, 64'h1C,               1, 64'h1C};
    vecs[1] = '{2, 64'hF01C,             1, 64'hF01C};
    vecs[2] = '{3, 64'hE0F075,           1, 64'hE0F075};
    vecs[3] = '{4, 64'hE012E07C,         1, 64'hE07C};
    vecs[4] = '{8, 64'hE11477E1F014F077, 1, 64'hE11477E1F014F077};
    vecs[5] = '{4, 64'hE0F0121C,         1, 64'h1C};
    codes   = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B,
                8'h42, 8'h4B, 8'h75, 8'h6B, 8'h74, 8'h5A, 8'h29};

    wait_cyc(5);
    check("reset_key_lo", ps2_key[63:0], 64'h0);
    check("reset_strobe", 64'(ps2_key[64]), 64'd0);
    check("reset_err", 64'(frame_err), 64'd0);
    reset_n = 1'b1;
    wait_cyc(20);

    for (int v = 0; v < 6; v++) begin
      bts = vecs[v].bytes;
      for (int i = 0; i < vecs[v].n; i++) send_byte(bts[8*(vecs[v].n-1-i) +: 8], 40);
      wait_cyc(60);
      expect_events($sformatf("vec%0d", v), vecs[v].emits, vecs[v].key, 0);
    end

    send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
    wait_cyc(60);
    expect_events("bad_stop", 0, 64'h0, 1);

    send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
    wait_cyc(60);
`ifdef PS2_PARITY_CHK_EN
    expect_events("bad_parity", 0, 64'h0, 1);
`else
    expect_events("bad_parity", 1, 64'h1C, 0);
`endif

    send_frame(8'h5A, 1'b1, 1'b0, 11, 3);
    wait_cyc(60);
    expect_events("glitch", 1, 64'h5A, 0);

    send_byte(8'hE0, 3000);
    send_byte(8'h1C, 60);
    expect_events("byte_timeout", 1, 64'h1C, 0);

    send_frame(8'h1C, 1'b1, 1'b0, 4, -1);
    wait_cyc(2500);
    send_byte(8'h1C, 60);
    expect_events("frame_timeout", 1, 64'h1C, 1);

    send_frame(8'h33, 1'b1, 1'b0, 5, -1);
    reset_n = 1'b0;
    wait_cyc(3);
    check("midreset_key", ps2_key[63:0], 64'h0);
    check("midreset_strobe", 64'(ps2_key[64]), 64'd0);
    check("midreset_err", 64'(frame_err), 64'd0);
    reset_n = 1'b1;
    exp_tog = 1'b0;
    key_q.delete();
    err_pulses = 0;
    wait_cyc(20);
    send_byte(8'h1C, 60);
    expect_events("after_reset", 1, 64'h1C, 0);

    pend.delete();
    exp_q.delete();
    for (int s = 0; s < 20; s++) begin
      logic [7:0] code;
      seq.delete();
      code = codes[$urandom_range(0, 13)];
      case ($urandom_range(0, 5))
        0, 1: begin
          if ($urandom_range(0, 1) == 1) seq.push_back(8'hE0);
          seq.push_back(code);
        end
        2, 3: begin
          if ($urandom_range(0, 1) == 1) seq.push_back(8'hE0);
          seq.push_back(8'hF0);
          seq.push_back(code);
        end
        4: begin
          seq.push_back(8'hE0);
          if ($urandom_range(0, 1) == 1) seq.push_back(8'hF0);
          seq.push_back(8'h12);
          seq.push_back(8'hE0);
          seq.push_back(code);
        end
        default: begin
          seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        end
      endcase
      foreach (seq[i]) begin
        model_byte(seq[i]);
        send_byte(seq[i], $urandom_range(20, 150));
      end
      wait_cyc(60);
      if (exp_q.size() % 2 == 1) exp_tog = ~exp_tog;
      check($sformatf("rnd%0d_count", s), 64'(key_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
        check($sformatf("rnd%0d_key%0d", s, i), (i < key_q.size()) ? key_q[i] : 64'h0, exp_q[i]);
      check($sformatf("rnd%0d_tog", s), 64'(ps2_key[64]), 64'(exp_tog));
      check($sformatf("rnd%0d_err", s), 64'(err_pulses), 64'd0);
      key_q.delete();
      exp_q.delete();
      err_pulses = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(10 * 99000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
